// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int ROW_W      = 4;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  // Index of the lowest-numbered active-low column; 0 when none is low.
  function automatic logic [1:0] lowest_low_col(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!c[i]) begin
        idx = i[1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/debounce_counter.sv
// Up-counter shared by the row dwell and press/release debounce intervals.
module debounce_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear has priority so every state change starts from zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CNT_W{1'b0}};
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == limit);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce; all outputs registered.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DWELL      = 2000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            cols,
  output logic [ROW_W-1:0]      rows,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam int CNT_MAX = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
  localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // The high seen in HELD is the first of the release run, so one fewer here.
  localparam logic [CNT_W-1:0] RELEASE_LAST =
    CNT_W'((DEBOUNCE_CYCLES > 1) ? (DEBOUNCE_CYCLES - 2) : 0);

  state_e                  state_q, state_d;
  logic [1:0]              row_idx_q, row_idx_d;
  logic [1:0]              col_idx_q, col_idx_d;
  logic [ROW_W-1:0]        rows_q, rows_d;
  logic [KEY_CODE_W-1:0]   key_code_q, key_code_d;
  logic                    key_valid_q, key_valid_d;
  logic                    key_held_q, key_held_d;
  logic                    cnt_clear_s, cnt_en_s, cnt_done_s;
  logic [CNT_W-1:0]        cnt_limit_s;

  debounce_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear_s),
    .enable (cnt_en_s),
    .limit  (cnt_limit_s),
    .done   (cnt_done_s)
  );

  // Next-state, counter control and output next values.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    cnt_clear_s = 1'b0;
    cnt_en_s    = 1'b0;
    cnt_limit_s = PRESS_LAST;
    case (state_q)
      SCAN: begin
        cnt_limit_s = DWELL_LAST;
        if (cnt_done_s) begin
          cnt_clear_s = 1'b1;
          if (cols != 4'b1111) begin
            col_idx_d = lowest_low_col(cols);
            state_d   = PRESS_DB;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      PRESS_DB: begin
        if (cols[col_idx_q]) begin
          cnt_clear_s = 1'b1;
          row_idx_d   = row_idx_q + 2'd1;
          state_d     = SCAN;
        end else if (cnt_done_s) begin
          cnt_clear_s = 1'b1;
          key_code_d  = {row_idx_q, col_idx_q};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      HELD: begin
        cnt_clear_s = 1'b1;
        if (cols[col_idx_q]) begin
          state_d = RELEASE_DB;
        end else begin
          state_d = HELD;
        end
      end
      RELEASE_DB: begin
        cnt_limit_s = RELEASE_LAST;
        if (!cols[col_idx_q]) begin
          cnt_clear_s = 1'b1;
          state_d     = HELD;
        end else if (cnt_done_s) begin
          cnt_clear_s = 1'b1;
          key_held_d  = 1'b0;
          row_idx_d   = row_idx_q + 2'd1;
          state_d     = SCAN;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      default: begin
        cnt_clear_s = 1'b1;
        state_d     = SCAN;
      end
    endcase
    rows_d = ~(4'b0001 << row_idx_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SCAN;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      rows_q      <= 4'b1110;
      key_code_q  <= 4'b0000;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      rows_q      <= rows_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign rows      = rows_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: directed vector table plus randomized run-length reference model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cols = 4'b1111;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scanner #(.SCAN_DWELL(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;

  // Reference model: active row, dwell ticks, candidate column (-1 none), stable-run length.
  int         m_row = 0;
  int         m_dwell = 0;
  int         m_cand = -1;
  int         m_run = 0;
  logic       m_held = 1'b0;
  logic       m_valid = 1'b0;
  logic [3:0] m_code = 4'b0000;

  task automatic model_step(input logic r, input logic [3:0] c);
    m_valid = 1'b0;
    if (!r) begin
      m_row = 0; m_dwell = 0; m_cand = -1; m_run = 0;
      m_held = 1'b0; m_code = 4'b0000;
    end else if (m_held) begin
      if (c[m_cand]) begin
        m_run++;
        if (m_run == DB) begin
          m_held = 1'b0; m_cand = -1; m_run = 0;
          m_row = (m_row + 1) % 4; m_dwell = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (m_cand >= 0) begin
      if (c[m_cand]) begin
        m_cand = -1; m_run = 0; m_row = (m_row + 1) % 4; m_dwell = 0;
      end else begin
        m_run++;
        if (m_run == DB) begin
          m_held = 1'b1; m_valid = 1'b1; m_run = 0;
          m_code = {m_row[1:0], m_cand[1:0]};
        end
      end
    end else begin
      m_dwell++;
      if (m_dwell == SD) begin
        m_dwell = 0;
        if (c != 4'b1111) begin
          for (int i = 3; i >= 0; i--) if (!c[i]) m_cand = i;
          m_run = 0;
        end else begin
          m_row = (m_row + 1) % 4;
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic [3:0] c);
    logic [3:0] one_l;
    logic [3:0] exp_rows;
    reset = r;
    cols  = c;
    @(posedge clk);
    model_step(r, c);
    #1;
    one_l = 4'b0001;
    exp_rows = ~(one_l << m_row);
    if (key_valid === 1'b1) valid_seen++;
    checks++;
    if (rows !== exp_rows || key_code !== m_code || key_valid !== m_valid || key_held !== m_held) begin
      errors++;
      $display("FAIL model t=%0t rows=%b exp %b code=%b exp %b valid=%b exp %b held=%b exp %b",
               $time, rows, exp_rows, key_code, m_code, key_valid, m_valid, key_held, m_held);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] cols;
    int         n;
    logic [3:0] e_rows;
    logic [3:0] e_code;
    logic       e_held;
    int         e_valid;
  } vec_t;

  vec_t vt[$];

  initial begin
    // Directed sequence: reset, idle scan, press row1/col2, bouncy release,
    // short press abort, reset mid-debounce, multi-low on row3, other keys while held.
    vt.push_back('{1'b0, 4'b1111,  2, 4'b1110, 4'b0000, 1'b0, 0});
    vt.push_back('{1'b1, 4'b1111, 40, 4'b1011, 4'b0000, 1'b0, 0});
    vt.push_back('{1'b1, 4'b1111, 12, 4'b1101, 4'b0000, 1'b0, 0});
    vt.push_back('{1'b1, 4'b1011, 20, 4'b1101, 4'b0110, 1'b1, 1});
    vt.push_back('{1'b1, 4'b1111,  3, 4'b1101, 4'b0110, 1'b1, 0});
    vt.push_back('{1'b1, 4'b1011,  3, 4'b1101, 4'b0110, 1'b1, 0});
    vt.push_back('{1'b1, 4'b1111,  3, 4'b1101, 4'b0110, 1'b1, 0});
    vt.push_back('{1'b1, 4'b1011,  3, 4'b1101, 4'b0110, 1'b1, 0});
    vt.push_back('{1'b1, 4'b1111,  8, 4'b1011, 4'b0110, 1'b0, 0});
    vt.push_back('{1'b1, 4'b1111,  8, 4'b1110, 4'b0110, 1'b0, 0});
    vt.push_back('{1'b1, 4'b1111,  3, 4'b1110, 4'b0110, 1'b0, 0});
    vt.push_back('{1'b1, 4'b1110,  3, 4'b1110, 4'b0110, 1'b0, 0});
    vt.push_back('{1'b1, 4'b1111,  1, 4'b1101, 4'b0110, 1'b0, 0});
    vt.push_back('{1'b1, 4'b1111,  3, 4'b1101, 4'b0110, 1'b0, 0});
    vt.push_back('{1'b1, 4'b1101,  6, 4'b1101, 4'b0110, 1'b0, 0});
    vt.push_back('{1'b0, 4'b1101,  1, 4'b1110, 4'b0000, 1'b0, 0});
    vt.push_back('{1'b1, 4'b1111,  8, 4'b1011, 4'b0000, 1'b0, 0});
    vt.push_back('{1'b1, 4'b1111,  4, 4'b0111, 4'b0000, 1'b0, 0});
    vt.push_back('{1'b1, 4'b0101, 12, 4'b0111, 4'b1101, 1'b1, 1});
    vt.push_back('{1'b1, 4'b0001, 10, 4'b0111, 4'b1101, 1'b1, 0});
    vt.push_back('{1'b1, 4'b1111,  8, 4'b1110, 4'b1101, 1'b0, 0});

    foreach (vt[k]) begin
      valid_seen = 0;
      repeat (vt[k].n) tick(vt[k].rst, vt[k].cols);
      checks++;
      if (rows !== vt[k].e_rows || key_code !== vt[k].e_code ||
          key_held !== vt[k].e_held || valid_seen != vt[k].e_valid) begin
        errors++;
        $display("FAIL vec%0d rows=%b exp %b code=%b exp %b held=%b exp %b pulses=%0d exp %0d",
                 k, rows, vt[k].e_rows, key_code, vt[k].e_code, key_held, vt[k].e_held,
                 valid_seen, vt[k].e_valid);
      end
    end

    // Randomized bursts: idle, single keys, multi-key patterns, bounce, rare resets.
    tick(1'b0, 4'b1111);
    for (int b = 0; b < 300; b++) begin
      logic [3:0] c;
      logic       r;
      int         dur;
      c   = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom());
      r   = ($urandom_range(0, 59) != 0);
      dur = $urandom_range(1, 24);
      repeat (dur) tick(r, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
